// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, op/funct encodings and sequencer state
package alu_pkg;

  // Decoded ALU control codes
  localparam logic [2:0] CTRL_ADD  = 3'b000;
  localparam logic [2:0] CTRL_SUB  = 3'b001;
  localparam logic [2:0] CTRL_AND  = 3'b010;
  localparam logic [2:0] CTRL_OR   = 3'b011;
  localparam logic [2:0] CTRL_SLL  = 3'b100;
  localparam logic [2:0] CTRL_MULL = 3'b101;
  localparam logic [2:0] CTRL_MULH = 3'b110;
  localparam logic [2:0] CTRL_ILL  = 3'b111;

  // ALU_op encodings coming from the ID/EX stage
  localparam logic [1:0] OP_RTYPE = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_SLL   = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  // R-type funct codes
  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_AND  = 4'b0010;
  localparam logic [3:0] FN_OR   = 4'b0011;
  localparam logic [3:0] FN_SLL  = 4'b0100;
  localparam logic [3:0] FN_MULL = 4'b0101;
  localparam logic [3:0] FN_MULH = 4'b0110;

  // Sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/alu_seq_multiplier.sv
// rtl/alu_seq_multiplier.sv - iterative unsigned shift-add multiplier
module alu_seq_multiplier
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplr;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]    cnt;
  logic                active;

  assign active   = (cnt != '0);
  assign acc_next = acc + (mplr[0] ? mcand : '0);
  // The last iteration's partial sum is the full product, exposed on the done cycle
  assign done     = active && (cnt == CNT_W'(1));
  assign product  = acc_next;

  // One add-and-shift per cycle; reset aborts any product in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start) begin
      mcand <= {{DATA_W{1'b0}}, a};
      mplr  <= b;
      acc   <= '0;
      cnt   <= CNT_W'(DATA_W);
    end else if (active) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU decode, single-cycle datapath and multiply sequencing
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         ALU_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  src_a,
  input  logic [DATA_W-1:0]  src_b,
  output logic [2:0]         ALU_ctrl,
  output logic [DATA_W-1:0]  result,
  output logic               out_valid,
  output logic               illegal,
  output logic               busy
);

  localparam int SH_W = $clog2(DATA_W);

  seq_state_t          state;
  logic [2:0]          ctrl_dec;
  logic [DATA_W-1:0]   sc_result;
  logic                accept;
  logic                is_mul;
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = ~in_ready;
  assign accept    = in_valid & in_ready;
  assign is_mul    = (ctrl_dec == CTRL_MULL) || (ctrl_dec == CTRL_MULH);
  assign mul_start = accept & is_mul;

  // Decode ALU_op/funct into the control code; unknown R-type functs map to illegal
  always_comb begin
    ctrl_dec = CTRL_ADD;
    case (ALU_op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_W'(FN_ADD):  ctrl_dec = CTRL_ADD;
          FUNCT_W'(FN_SUB):  ctrl_dec = CTRL_SUB;
          FUNCT_W'(FN_AND):  ctrl_dec = CTRL_AND;
          FUNCT_W'(FN_OR):   ctrl_dec = CTRL_OR;
          FUNCT_W'(FN_SLL):  ctrl_dec = CTRL_SLL;
          FUNCT_W'(FN_MULL): ctrl_dec = CTRL_MULL;
          FUNCT_W'(FN_MULH): ctrl_dec = CTRL_MULH;
          default:           ctrl_dec = CTRL_ILL;
        endcase
      end
      OP_SUB:  ctrl_dec = CTRL_SUB;
      OP_SLL:  ctrl_dec = CTRL_SLL;
      OP_ADD:  ctrl_dec = CTRL_ADD;
      default: ctrl_dec = CTRL_ADD;
    endcase
  end

  // Single-cycle datapath; illegal and multiply codes produce zero here
  always_comb begin
    sc_result = '0;
    case (ctrl_dec)
      CTRL_ADD: sc_result = src_a + src_b;
      CTRL_SUB: sc_result = src_a - src_b;
      CTRL_AND: sc_result = src_a & src_b;
      CTRL_OR:  sc_result = src_a | src_b;
      CTRL_SLL: sc_result = src_a << src_b[SH_W-1:0];
      default:  sc_result = '0;
    endcase
  end

  alu_seq_multiplier #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (src_a),
    .b       (src_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Handshake FSM and output registers; out_valid is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ALU_ctrl  <= CTRL_ADD;
      result    <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ALU_ctrl <= ctrl_dec;
            if (is_mul) begin
              state <= ST_MUL;
            end else begin
              result    <= sc_result;
              out_valid <= 1'b1;
              illegal   <= (ctrl_dec == CTRL_ILL);
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state     <= ST_IDLE;
            result    <= (ALU_ctrl == CTRL_MULH) ? mul_product[2*DATA_W-1:DATA_W]
                                                 : mul_product[DATA_W-1:0];
            out_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  localparam int DW = 16;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    ALU_op;
  logic [FW-1:0] funct;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic [2:0]    ALU_ctrl;
  logic [DW-1:0] result;
  logic          out_valid;
  logic          illegal;
  logic          busy;

  alu_op_sequencer #(
    .DATA_W  (DW),
    .FUNCT_W (FW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALU_op    (ALU_op),
    .funct     (funct),
    .src_a     (src_a),
    .src_b     (src_b),
    .ALU_ctrl  (ALU_ctrl),
    .result    (result),
    .out_valid (out_valid),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] res;
    bit          ill;
  } exp_t;

  exp_t        pend[$];
  int          cyc;
  int          ready_from;
  logic [31:0] m_ctrl;
  logic [31:0] last_out;
  bit          last_acc;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference decode: control code for an op/funct pair
  function automatic int ref_ctrl(input logic [1:0] op, input logic [FW-1:0] fn);
    if (op == 2'd1) return 1;
    if (op == 2'd2) return 4;
    if (op == 2'd3) return 0;
    if (int'(fn) <= 6) return int'(fn);
    return 7;
  endfunction

  // Reference arithmetic on plain integers, modulo 2^DW
  function automatic logic [31:0] ref_res(input int c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint unsigned ua, ub, m;
    ua = longint'(a);
    ub = longint'(b);
    m  = (64'd1 << DW) - 1;
    case (c)
      0: return 32'((ua + ub) & m);
      1: return 32'((ua - ub) & m);
      2: return 32'(ua & ub);
      3: return 32'(ua | ub);
      4: return 32'((ua << (ub % DW)) & m);
      5: return 32'((ua * ub) & m);
      6: return 32'((ua * ub) >> DW);
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    bit   acc;
    bit   rst;
    int   c;
    bit   ev;
    acc = in_valid && !reset && (cyc >= ready_from);
    rst = reset;
    c   = ref_ctrl(ALU_op, funct);
    @(posedge clk);
    #1;
    cyc++;
    last_acc = acc;
    if (rst) begin
      pend.delete();
      ready_from = 0;
      m_ctrl = 0;
      chk("rst_result", 32'(result), 0);
      chk("rst_illegal", 32'(illegal), 0);
    end else if (acc) begin
      exp_t e;
      m_ctrl = 32'(c);
      e.res = ref_res(c, src_a, src_b);
      e.ill = (c == 7);
      if (c == 5 || c == 6) begin
        e.due = cyc + DW;
        ready_from = cyc + DW;
      end else begin
        e.due = cyc;
      end
      pend.push_back(e);
    end
    chk("in_ready", 32'(in_ready), 32'(cyc >= ready_from));
    chk("busy", 32'(busy), 32'(cyc < ready_from));
    chk("ALU_ctrl", 32'(ALU_ctrl), m_ctrl);
    ev = (pend.size() > 0) && (pend[0].due == cyc);
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) begin
      chk("result", 32'(result), pend[0].res);
      chk("illegal", 32'(illegal), 32'(pend[0].ill));
      last_out = 32'(result);
      void'(pend.pop_front());
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [FW-1:0] fn,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    ALU_op   = op;
    funct    = fn;
    src_a    = a;
    src_b    = b;
    for (int i = 0; i < 3 * DW; i++) begin
      tick();
      if (last_acc) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    ready_from = 0;
    m_ctrl = 0;
    last_out = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    ALU_op = 2'd0;
    funct = '0;
    src_a = '0;
    src_b = '0;
    tick();
    tick();
    reset = 1'b0;
    idle(1);

    // add overflow into the sign bit
    issue(2'b11, 4'h0, 16'h7FFF, 16'h0001);
    idle(1);
    chk("plan_add", last_out, 32'h8000);

    // multiply low and high halves
    issue(2'b00, 4'h5, 16'h0123, 16'h0010);
    idle(DW + 1);
    chk("plan_mul_lo", last_out, 32'h1230);
    issue(2'b00, 4'h6, 16'hFFFF, 16'hFFFF);
    idle(DW + 1);
    chk("plan_mul_hi", last_out, 32'hFFFE);

    // back-to-back single-cycle ops
    issue(2'b00, 4'h1, 16'h0005, 16'h0007);
    issue(2'b00, 4'h2, 16'hF0F0, 16'h0FF0);
    issue(2'b10, 4'h0, 16'h0001, 16'h0013);
    idle(1);
    chk("plan_shift", last_out, 32'h0008);

    // undefined funct
    issue(2'b00, 4'hF, 16'h1234, 16'h5678);
    idle(1);

    // add held during a multiply
    issue(2'b00, 4'h5, 16'h00FF, 16'h0101);
    issue(2'b11, 4'h0, 16'h0003, 16'h0004);
    idle(2);
    chk("plan_held_add", last_out, 32'h0007);

    // reset in the middle of a multiply
    issue(2'b00, 4'h5, 16'h1111, 16'h2222);
    idle(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(DW + 2);
    issue(2'b11, 4'h0, 16'h0100, 16'h0023);
    idle(1);
    chk("plan_post_rst_add", last_out, 32'h0123);

    // randomized traffic with occasional resets
    for (int k = 0; k < 200; k++) begin
      logic [1:0]    op;
      logic [FW-1:0] fn;
      op = 2'($urandom_range(0, 3));
      fn = FW'($urandom_range(0, 9));
      issue(op, fn, 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end
    idle(DW + 3);
    chk("drain", 32'(pend.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Parametrised successor to the combinational ALU control decode. It decodes `ALU_op`/`funct` into `ALU_ctrl`, executes the selected operation on registered operands, and runs multiply as an iterative shift-add sequence with a valid/ready handshake. It sits between the ID/EX stage and the register writeback path, and stalls issue via `in_ready` while a multiply is in flight.

## Interface
- `DATA_W`, default 16: operand and result width; must be a power of two, ≥ 4.
- `FUNCT_W`, default 4: width of the `funct` field.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; a transfer occurs when `in_valid & in_ready` at a clock edge.
- `ALU_op`  in  2  00 = R-type (use funct), 01 = sub (branch compare), 10 = shift left (slti path), 11 = add (addi/lw/sw).
- `funct`  in  FUNCT_W  R-type function code.
- `src_a`, `src_b`  in  DATA_W  operands.
- `ALU_ctrl`  out  3  registered decoded control for the accepted operation.
- `result`  out  DATA_W  operation result, valid while `out_valid`.
- `out_valid`  out  1  one-cycle pulse; no backpressure, the consumer must capture it.
- `illegal`  out  1  qualifies `out_valid`; the accepted R-type funct was undefined.
- `busy`  out  1  a multiply is in progress (equals `~in_ready`).

## Operation
- Decode for `ALU_op`=00:
  - 0000 add → 000
  - 0001 sub → 001
  - 0010 and → 010
  - 0011 or → 011
  - 0100 shift left → 100
  - 0101 mul low → 101
  - 0110 mul high → 110
  - any other funct → 111, which sets `illegal`.
- Decode for other `ALU_op` values: 01 → 001, 10 → 100, 11 → 000.
- Arithmetic is modulo 2^DATA_W. Shift is `src_a << src_b[log2(DATA_W)-1:0]`, logical, zero fill. Mul is unsigned, with a full 2·DATA_W product; 101 returns the low half, 110 the high half.
- Illegal operation: `result` = 0, `illegal` = 1 together with `out_valid`; handled as a single-cycle op.
- FSM has two states, IDLE and MUL.
  - IDLE: `in_ready` = 1. Accepting a single-cycle op stays in IDLE. Accepting a mul latches the operands, clears the accumulator, loads the counter with DATA_W, and moves to MUL.
  - MUL: `in_ready` = 0. Each cycle adds the multiplicand if multiplier bit 0 is set, shifts, and decrements the counter. When the counter reaches 1, the state returns to IDLE and `result`/`out_valid` are registered on that same edge.
- `in_valid` while `busy`: ignored, not accepted; the requester must hold it.
- `ALU_ctrl` updates only on accept and holds its value until the next accept.

## Timing
- Reset values: `ALU_ctrl` = 000, `result` = 0, `out_valid` = 0, `illegal` = 0, `busy` = 0, `in_ready` = 1, state IDLE.
- Single-cycle ops: `out_valid` is high in the cycle after the accept edge (latency 1). Throughput is 1 per cycle; back-to-back accepts produce consecutive `out_valid` pulses.
- Mul: `out_valid` is high DATA_W+1 cycles after the accept edge.
  - `in_ready` is low for DATA_W cycles.
  - `in_ready` returns high in the same cycle `out_valid` pulses, so a new op may be accepted in that cycle.
- Reset mid-mul: aborts on the next edge. The accumulator and counter are cleared, no `out_valid` is produced for the aborted op, and `in_ready` = 1 in the following cycle.
- `out_valid` is never high for two consecutive cycles for the same operation.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_ctrl` codes as named constants (000 to 111);
  - `ALU_op` encodings;
  - funct codes;
  - the FSM state enum.
- Sub-module `alu_seq_multiplier` implements the shift-add datapath: operands, accumulator, counter, a start/done pulse interface, and a reset-abort input. The top level keeps decode, the single-cycle datapath, the handshake, and output registers.

## Test plan
- `ALU_op`=11, `src_a`=0x7FFF, `src_b`=0x0001 → next cycle `out_valid`=1, `result`=0x8000, `ALU_ctrl`=000, `illegal`=0.
- `ALU_op`=00, funct 0101, `src_a`=0x0123, `src_b`=0x0010 → `in_ready`=0 for 16 cycles, then `out_valid` with `result`=0x1230 at cycle 17. Repeat with funct 0110, `src_a`=`src_b`=0xFFFF → `result`=0xFFFE.
- Back-to-back accepts of sub 5−7, and 0xF0F0 & 0x0FF0, then shift 0x0001 by 0x0013 → three consecutive pulses: 0xFFFE, 0x00F0, 0x0008.
- funct 1111 with `ALU_op`=00 → `out_valid`=1, `illegal`=1, `result`=0, `ALU_ctrl`=111.
- Hold `in_valid` with an add during a mul → add is not accepted until `in_ready` rises; its result appears one cycle after the mul's `out_valid`.
- Assert `reset` at mul iteration 5 → no `out_valid`, all outputs at reset values, `in_ready`=1 the cycle after reset deasserts; a following add completes normally.
